// File: rtl/byte_mem_pkg.sv
// Shared definitions for the byte-addressable sequenced memory:
// request size encodings, sequencer state codes and a size decoder.
package byte_mem_pkg;

  // Request size field encodings
  localparam logic [1:0] SZ_B = 2'b00;  // 1 byte
  localparam logic [1:0] SZ_H = 2'b01;  // 2 bytes
  localparam logic [1:0] SZ_W = 2'b10;  // 4 bytes
  localparam logic [1:0] SZ_D = 2'b11;  // 8 bytes

  // Sequencer state codes
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Number of bytes moved by a transaction of the given size
  function automatic logic [3:0] size_to_nbytes(input logic [1:0] size);
    logic [3:0] n;
    n = 4'd1;
    case (size)
      SZ_B: n = 4'd1;
      SZ_H: n = 4'd2;
      SZ_W: n = 4'd4;
      SZ_D: n = 4'd8;
      default: n = 4'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/byte_mem_array.sv
// Byte-wide scratch storage: DEPTH x 8 bits, one synchronous write port,
// one combinational read port, synchronous clear on reset.
// Before the first reset, byte i holds i[7:0].
module byte_mem_array #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [7:0] cells [DEPTH];

  // One register per byte so each can carry its own power-up value
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic [7:0] byte_q = 8'(i);

    // Clear on reset, otherwise take the write when addressed
    always_ff @(posedge clk) begin
      if (reset) begin
        byte_q <= '0;
      end else if (we_i && (addr_i == ADDR_W'(i))) begin
        byte_q <= wdata_i;
      end
    end

    assign cells[i] = byte_q;
  end

  assign rdata_o = cells[addr_i];

endmodule

// File: rtl/byte_mem_seq.sv
// Byte-addressable memory with 1/2/4/8-byte little-endian transactions.
// The storage port is one byte wide, so a sequencer moves one byte per
// cycle between a valid/ready request channel and a valid/ready response.
// Optional: define BYTE_MEM_SEQ_ALIGN_CHECK_EN to reject misaligned
// requests with rsp_err instead of performing them.
module byte_mem_seq
  import byte_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DATA_BYTES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [1:0]              req_size,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [8*DATA_BYTES-1:0] rsp_rdata,
  output logic                    rsp_err
);

  localparam int unsigned KW = $clog2(DATA_BYTES);

  logic [1:0]              state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic                    we_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [1:0]              size_q;
  logic [8*DATA_BYTES-1:0] wdata_q;
  logic [8*DATA_BYTES-1:0] rdata_q;

  logic                    accept;
  logic                    last;
  logic                    access_ok;
  logic [ADDR_W-1:0]       mem_addr;
  logic [7:0]              mem_rdata;
  logic                    mem_we;

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign accept    = req_valid && req_ready;
  assign last      = (4'(k_q) == (size_to_nbytes(size_q) - 4'd1));
  // Address arithmetic is ADDR_W wide, so wrap past DEPTH-1 is implicit
  assign mem_addr  = addr_q + ADDR_W'(k_q);
  assign mem_we    = (state_q == ST_BUSY) && we_q && access_ok;

`ifdef BYTE_MEM_SEQ_ALIGN_CHECK_EN
  logic err_q;
  logic misaligned;

  assign misaligned = |(req_addr & ADDR_W'(size_to_nbytes(req_size) - 4'd1));
  assign access_ok  = !err_q;
  assign rsp_err    = err_q;

  // Error flag captured at accept, held until the next accept
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misaligned;
    end
  end
`else
  assign access_ok = 1'b1;
  assign rsp_err   = 1'b0;
`endif

  byte_mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (wdata_q[8*k_q +: 8]),
    .rdata_o (mem_rdata)
  );

  // Sequencer next state and byte index
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_BUSY;
          k_d     = '0;
        end
      end
      ST_BUSY: begin
        // A rejected request spends a single cycle here, then responds
        if (!access_ok || last) begin
          state_d = ST_RESP;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Request capture and read-data assembly
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= SZ_B;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      size_q  <= req_size;
      wdata_q <= req_wdata;
      rdata_q <= '0;
    end else if ((state_q == ST_BUSY) && !we_q && access_ok) begin
      rdata_q[8*k_q +: 8] <= mem_rdata;
    end
  end

endmodule

// File: doc/byte_mem_seq.md
Name: byte_mem_seq

Overview:
Parametrised byte-addressable memory with variable-size little-endian read and write transactions of 1, 2, 4 or 8 bytes.
- Storage has a single byte-wide port, so a sequencer FSM moves one byte per cycle.
- Uses a valid/ready request channel and a valid/ready response channel.
- Sits between the lab datapath's load/store unit and local scratch storage.

Parameters:
ADDR_W, 4, byte address width; DEPTH = 2**ADDR_W bytes
DATA_BYTES, 8, maximum transaction bytes; data buses are 8*DATA_BYTES wide; must be 8

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  start byte address
req_size  in  2  00 = 1 byte, 01 = 2, 10 = 4, 11 = 8
req_wdata  in  64  write data, byte k at bits [8k+7:8k]
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  64  read data, zero-extended; 0 for writes
rsp_err  out  1  misalignment error (see Optional Feature)

Behaviour:
- Reset:
  - state = IDLE; req_ready = 1 the cycle after reset deasserts.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - All DEPTH bytes are cleared to 0 in the reset cycle.
  - Simulation time-zero contents are byte i = i[7:0].
- Reset during BUSY or RESP aborts the transaction; the aborted response is never presented.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch we, addr, size and wdata; set byte index k = 0 and N = 1 << size; go to BUSY.
- BUSY:
  - req_ready = 0.
  - Each cycle, access byte address (addr + k) mod DEPTH. Wrap-around is silent, with no error.
  - Read: rsp_rdata byte k <= mem[address].
  - Write: mem[address] <= wdata byte k.
  - When k == N-1, go to RESP; otherwise k <= k + 1.
- RESP:
  - rsp_valid = 1. rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_ready, go to IDLE with rsp_valid = 0.
- Latency: the request is accepted at edge T and rsp_valid rises after edge T+N.
  - Read 1 byte = 1 busy cycle; read 8 bytes = 8 busy cycles.
  - Next accept is no earlier than the cycle after the response handshake. There is no overlap.
- Read-data clearing:
  - rsp_rdata is cleared to 0 on accept.
  - Bytes at index N and above remain 0.
  - Write responses carry rsp_rdata = 0.
- req_* inputs are ignored while req_ready = 0.
- A 4- or 8-byte access may wrap past DEPTH-1 to byte 0 in a single transaction.

Optional Feature:
Macro BYTE_MEM_SEQ_ALIGN_CHECK_EN.
- Defined:
  - A request with addr mod N != 0 is accepted but performs no memory access.
  - It goes IDLE -> RESP after one cycle with rsp_err = 1 and rsp_rdata = 0.
  - Aligned requests behave normally with rsp_err = 0.
- Undefined:
  - No check is made; misaligned and wrapping accesses proceed.
  - rsp_err is tied to 0.

Decomposition:
- Package byte_mem_pkg:
  - size encoding constants SZ_B/SZ_H/SZ_W/SZ_D.
  - FSM state enum.
  - function size_to_nbytes(size) returning 1..8.
- Sub-module byte_mem_array holds storage:
  - DEPTH x 8 bits, one write port (synchronous, gated by we) and one combinational read port.
  - Synchronous reset clear.
  - Time-zero init.
- The top level holds the FSM, index counter, data assembly and handshakes.

Test Plan:
- Reset, then read size 11 at addr 0 -> rsp_valid after 8 busy cycles, rsp_rdata = 0, rsp_err = 0.
- Write size 11 at addr 0, data 0x0807060504030201; then read size 10 at addr 4 -> rsp_rdata = 0x0000000008070605.
- Wrap: write size 10 at addr 12, data 0xDDCCBBAA, macro undefined; then read size 10 at addr 14 -> rsp_rdata = 0x00000000_00000000 | 0x0201DDCC (bytes 14,15,0,1 = CC,DD,01,02 after the previous test).
- Backpressure: hold rsp_ready = 0 for 5 cycles during RESP -> rsp_valid stays 1, rsp_rdata is stable, req_ready = 0; a req_valid pulse in this window is ignored.
- Reset in the 3rd BUSY cycle of an 8-byte write -> next cycle rsp_valid = 0 and req_ready = 1; a following read size 11 at addr 0 returns 0.
- Macro defined: read size 10 at addr 2 -> rsp_valid after 1 cycle, rsp_err = 1, rsp_rdata = 0, memory unchanged; read size 10 at addr 4 -> rsp_err = 0.
